// File: rtl/ecd_row_receiver_pkg.sv
// Shared constants and types for the ECD row receiver.
package ecd_pkg;
  localparam logic [31:0] ECD_ROW_ID_BASE = 32'h0000_C008;
  localparam int          ECD_DATA_WIDTH  = 256;

  typedef enum logic {ROW_HEADER, ROW_BODY} row_state_e;
endpackage

// File: rtl/ecd_row_receiver_if.sv
// AXI-Stream beat bundle used on both the receive and forward sides.
interface ecd_row_receiver_if #(parameter int DATA_WIDTH = ecd_pkg::ECD_DATA_WIDTH);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/ecd_row_receiver_skid.sv
// Two-entry skid FIFO; ready is registered so no combinational path runs from
// the downstream ready back to the upstream ready.
module axis_skid_buffer #(
  parameter int WIDTH = 257
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);
  logic [1:0][WIDTH-1:0] mem_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q, cnt_d;
  logic                  ready_q;
  logic                  push, pop;

  assign push        = in_valid_i & ready_q;
  assign pop         = out_valid_o & out_ready_i;
  assign cnt_d       = cnt_q + 2'(push) - 2'(pop);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign in_ready_o  = ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= in_data_i;
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
      cnt_q    <= cnt_d;
      // Look at the post-update occupancy so a full FIFO never advertises ready.
      ready_q  <= (cnt_d != 2'd2);
    end
  end
endmodule

// File: rtl/ecd_row_receiver.sv
// Frames incoming AXIS beats into rows, checks row header ids, counts rows and
// forwards the data with a regenerated row-boundary TLAST.
module ecd_row_receiver
  import ecd_pkg::*;
#(
  parameter int          DATA_WIDTH = ECD_DATA_WIDTH,
  parameter int          ROW_BEATS  = 64,
  parameter logic [31:0] ID_BASE    = ECD_ROW_ID_BASE,
  parameter int          CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  ecd_row_receiver_if.slave    axis_rx,
  ecd_row_receiver_if.master   axis_tx,
  output logic                 row_complete_out,
  output logic [CNT_WIDTH-1:0] row_count_out,
  output logic                 err_short_out,
  output logic                 err_long_out,
  output logic                 err_seq_out
);
  localparam int             BW        = (ROW_BEATS > 2) ? $clog2(ROW_BEATS) : 1;
  localparam logic [BW-1:0]  LAST_BEAT = BW'(ROW_BEATS - 1);

  row_state_e           state_q, state_d;
  logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [31:0]          exp_id_q, exp_id_d, cmp_id;
  logic [CNT_WIDTH-1:0] row_count_q, row_count_d;
  logic                 short_q, short_d, long_q, long_d, seq_q, seq_d;
  logic                 pulse_q, row_end, acc;
  logic [DATA_WIDTH:0]  skid_out;
  logic                 skid_valid;

  assign acc    = axis_rx.tvalid & axis_rx.tready;
  // A header arriving with clear is judged against the freshly reloaded base.
  assign cmp_id = clear ? ID_BASE : exp_id_q;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    exp_id_d    = exp_id_q;
    row_count_d = row_count_q;
    short_d     = short_q;
    long_d      = long_q;
    seq_d       = seq_q;
    row_end     = 1'b0;
    if (acc) begin
      if (state_q == ROW_HEADER) begin
        if (axis_rx.tdata[31:0] != cmp_id) seq_d = 1'b1;
        exp_id_d = axis_rx.tdata[31:0] + 32'd1;
        if (axis_rx.tlast) begin
          row_end = 1'b1;
          short_d = 1'b1;
        end else begin
          state_d    = ROW_BODY;
          beat_cnt_d = BW'(1);
        end
      end else if (axis_rx.tlast || beat_cnt_q == LAST_BEAT) begin
        row_end    = 1'b1;
        state_d    = ROW_HEADER;
        beat_cnt_d = '0;
        if (beat_cnt_q != LAST_BEAT) short_d = 1'b1;
        if (!axis_rx.tlast)          long_d  = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + BW'(1);
      end
    end
    if (row_end) row_count_d = row_count_q + CNT_WIDTH'(1);
    if (clear) begin
      state_d     = ROW_HEADER;
      beat_cnt_d  = '0;
      row_count_d = '0;
      short_d     = 1'b0;
      long_d      = 1'b0;
      seq_d       = 1'b0;
      if (!(acc && state_q == ROW_HEADER)) exp_id_d = ID_BASE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ROW_HEADER;
      beat_cnt_q  <= '0;
      exp_id_q    <= ID_BASE;
      row_count_q <= '0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      seq_q       <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      exp_id_q    <= exp_id_d;
      row_count_q <= row_count_d;
      short_q     <= short_d;
      long_q      <= long_d;
      seq_q       <= seq_d;
      pulse_q     <= row_end;
    end
  end

  axis_skid_buffer #(.WIDTH(DATA_WIDTH + 1)) u_skid (
    .clk        (clk),
    .rst        (reset),
    .in_data_i  ({row_end, axis_rx.tdata}),
    .in_valid_i (axis_rx.tvalid),
    .in_ready_o (axis_rx.tready),
    .out_data_o (skid_out),
    .out_valid_o(skid_valid),
    .out_ready_i(axis_tx.tready)
  );

  assign axis_tx.tdata    = skid_out[DATA_WIDTH-1:0];
  assign axis_tx.tlast    = skid_valid & skid_out[DATA_WIDTH];
  assign axis_tx.tvalid   = skid_valid;
  assign row_complete_out = pulse_q;
  assign row_count_out    = row_count_q;
  assign err_short_out    = short_q;
  assign err_long_out     = long_q;
  assign err_seq_out      = seq_q;
endmodule

// File: tb/tb_ecd_row_receiver.sv
// Directed scoreboard bench for ecd_row_receiver.
module tb_ecd_row_receiver;
  import ecd_pkg::*;
  localparam int DW = 256;
  localparam int RB = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        row_complete_out;
  logic [31:0] row_count_out;
  logic        err_short_out, err_long_out, err_seq_out;

  ecd_row_receiver_if #(.DATA_WIDTH(DW)) rx_if();
  ecd_row_receiver_if #(.DATA_WIDTH(DW)) tx_if();

  ecd_row_receiver #(.DATA_WIDTH(DW), .ROW_BEATS(RB), .ID_BASE(32'h0000_C008), .CNT_WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .clear           (clear),
    .axis_rx         (rx_if),
    .axis_tx         (tx_if),
    .row_complete_out(row_complete_out),
    .row_count_out   (row_count_out),
    .err_short_out   (err_short_out),
    .err_long_out    (err_long_out),
    .err_seq_out     (err_seq_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic last; logic [DW-1:0] data;} beat_t;
  beat_t sb[$];
  int    total = 0, bad = 0, pulses = 0;
  bit    rand_tx = 1'b0, rand_rx = 1'b0;

  // downstream ready: always 1, or a coin flip per cycle
  always @(posedge clk) begin
    #1;
    tx_if.tready = rand_tx ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor: occupancy check against upstream ready, then scoreboard pop
  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      if (row_complete_out) pulses++;
      if (rx_if.tready) begin
        total++;
        if (sb.size() >= 2) begin
          bad++;
          $display("FAIL rx_ready_when_full: tready=1 with %0d beats held, need <2", sb.size());
        end
      end
      if (tx_if.tvalid && tx_if.tready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL tx_unexpected: beat data=%h with empty scoreboard", tx_if.tdata[63:0]);
        end else begin
          e = sb.pop_front();
          if ({tx_if.tlast, tx_if.tdata} !== e) begin
            bad++;
            $display("FAIL tx_beat: got last=%0b data=%h want last=%0b data=%h",
                     tx_if.tlast, tx_if.tdata[63:0], e.last, e.data[63:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // called at posedge+1; returns at posedge+1 after the beat is accepted
  task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic exp_last, input bit clr);
    int t = 0;
    if (rand_rx) begin
      while ($urandom_range(0, 3) == 0) begin
        rx_if.tvalid = 1'b0;
        @(posedge clk); #1;
      end
    end
    rx_if.tdata  = d;
    rx_if.tlast  = last;
    rx_if.tvalid = 1'b1;
    clear        = clr;
    @(negedge clk);
    while (!rx_if.tready) begin
      t++;
      if (t > 2000) begin
        $display("FAIL rx_accept_timeout: tready stuck low, want acceptance");
        $fatal(1, "timeout");
      end
      @(negedge clk);
    end
    @(posedge clk);
    sb.push_back({exp_last, d});
    #1;
    rx_if.tvalid = 1'b0;
    clear        = 1'b0;
  endtask

  // tlast_at < 0: no upstream TLAST in the row
  task automatic send_row(input logic [31:0] id, input int n, input int tlast_at, input bit clr_last);
    logic [DW-1:0] d;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
      if (b == 0) d[31:0] = id;
      send_beat(d, (b == tlast_at), (b == tlast_at) || (b == RB - 1), clr_last && (b == n - 1));
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 5000) begin
      @(posedge clk); t++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d beats still pending, want 0", sb.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic chk_state(input string tag, input int np, input int cnt, input bit s, input bit l, input bit q);
    chk({tag, "_pulses"}, 64'(pulses - np), 64'(cnt));
    chk({tag, "_count"},  64'(row_count_out), 64'(cnt));
    chk({tag, "_short"},  64'(err_short_out), 64'(s));
    chk({tag, "_long"},   64'(err_long_out),  64'(l));
    chk({tag, "_seq"},    64'(err_seq_out),   64'(q));
  endtask

  initial begin
    int p0;
    rx_if.tdata  = '0;
    rx_if.tvalid = 1'b0;
    rx_if.tlast  = 1'b0;
    tx_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", 64'(rx_if.tready), 64'd0);
    chk("rst_tx_valid", 64'(tx_if.tvalid), 64'd0);
    chk("rst_tx_last",  64'(tx_if.tlast),  64'd0);
    chk("rst_pulse",    64'(row_complete_out), 64'd0);
    chk("rst_count",    64'(row_count_out), 64'd0);
    chk("rst_errs",     64'({err_short_out, err_long_out, err_seq_out}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready_rise", 64'(rx_if.tready), 64'd1);

    // two clean rows
    p0 = pulses;
    send_row(32'h0000_C008, RB, RB - 1, 1'b0);
    send_row(32'h0000_C009, RB, RB - 1, 1'b0);
    drain();
    chk_state("basic", p0, 2, 0, 0, 0);

    // random upstream gaps and downstream backpressure
    do_clear();
    p0 = pulses;
    rand_tx = 1'b1; rand_rx = 1'b1;
    for (int r = 0; r < 100; r++) send_row(32'h0000_C008 + 32'(r), RB, RB - 1, 1'b0);
    drain();
    rand_tx = 1'b0; rand_rx = 1'b0;
    @(posedge clk); #1;
    chk_state("random", p0, 100, 0, 0, 0);

    // short row, then a normal row
    do_clear();
    p0 = pulses;
    send_row(32'h0000_C008, 11, 10, 1'b0);
    send_row(32'h0000_C009, RB, RB - 1, 1'b0);
    drain();
    chk_state("short", p0, 2, 1, 0, 0);

    // long row, then a normal row
    do_clear();
    p0 = pulses;
    send_row(32'h0000_C008, RB, -1, 1'b0);
    send_row(32'h0000_C009, RB, RB - 1, 1'b0);
    drain();
    chk_state("long", p0, 2, 0, 1, 0);

    // out-of-sequence id, then resync
    do_clear();
    p0 = pulses;
    send_row(32'h0000_C008, RB, RB - 1, 1'b0);
    send_row(32'h0000_C00F, RB, RB - 1, 1'b0);
    send_row(32'h0000_C010, RB, RB - 1, 1'b0);
    drain();
    chk_state("seq", p0, 3, 0, 0, 1);

    // clear on the last beat of the third row
    do_clear();
    p0 = pulses;
    send_row(32'h0000_C00F, RB, RB - 1, 1'b0);
    send_row(32'h0000_C010, RB, RB - 1, 1'b0);
    send_row(32'h0000_C011, RB, RB - 1, 1'b1);
    drain();
    chk("clr_pulses", 64'(pulses - p0), 64'd3);
    chk("clr_count",  64'(row_count_out), 64'd0);
    chk("clr_errs",   64'({err_short_out, err_long_out, err_seq_out}), 64'd0);
    p0 = pulses;
    send_row(32'h0000_C008, RB, RB - 1, 1'b0);
    drain();
    chk_state("post_clr", p0, 1, 0, 0, 0);

    // reset in the middle of a row discards buffered beats
    send_row(32'h0000_C009, 5, -1, 1'b0);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("midrst_tx_valid", 64'(tx_if.tvalid), 64'd0);
    chk("midrst_count",    64'(row_count_out), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    p0 = pulses;
    send_row(32'h0000_C008, RB, RB - 1, 1'b0);
    drain();
    chk_state("post_rst", p0, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
